// File: rtl/usb_image_loader.sv
// Receives a 784-byte image frame (plus an optional label byte) over a USB byte stream.
// Optional build macro USB_LOADER_SYNC_EN: a frame starts only after header byte 0xA5.
module usb_image_loader #(
    parameter int unsigned IMAGE_SIZE   = 28,
    parameter int unsigned IMAGE_PIXELS = IMAGE_SIZE * IMAGE_SIZE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] usb_data_in,
    input  logic       usb_data_valid,
    input  logic       mode_train,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_ready,
    input  logic       frame_ack,
    output logic [7:0] label_out,
    output logic       label_valid,
    output logic       label_error,
    output logic       overflow,
    output logic       busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StLabel = 2'd2;
    localparam logic [1:0] StReady = 2'd3;

    localparam logic [9:0]  LastAddr = 10'(IMAGE_PIXELS - 1);
    localparam logic [10:0] NumPix   = 11'(IMAGE_PIXELS);
    localparam logic [7:0]  SyncByte = 8'hA5;

    logic [1:0] state_q, state_d;
    logic [9:0] count_q, count_d;
    logic       train_q, train_d;
    logic [7:0] label_q, label_d;
    logic       label_valid_q, label_valid_d;
    logic       label_error_q, label_error_d;
    logic       overflow_q, overflow_d;
    logic [7:0] rd_data_q;
    logic       start_frame;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] buffer [IMAGE_PIXELS];

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        train_d       = train_q;
        label_d       = label_q;
        label_valid_d = label_valid_q;
        label_error_d = label_error_q;
        overflow_d    = overflow_q;
        start_frame   = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = count_q;

        case (state_q)
            StIdle: start_frame = usb_data_valid;
            StLoad: begin
                if (usb_data_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 10'd1;
                    if (count_q == LastAddr) begin
                        state_d = train_q ? StLabel : StReady;
                    end
                end
            end
            StLabel: begin
                if (usb_data_valid) begin
                    label_d       = usb_data_in;
                    label_valid_d = 1'b1;
                    label_error_d = (usb_data_in > 8'd9);
                    state_d       = StReady;
                end
            end
            default: begin
                // Ack releases the frame and lets a byte in the same cycle start the next one.
                if (frame_ack) begin
                    state_d       = StIdle;
                    count_d       = '0;
                    label_valid_d = 1'b0;
                    label_error_d = 1'b0;
                    start_frame   = usb_data_valid;
                end else if (usb_data_valid) begin
                    overflow_d = 1'b1;
                end
            end
        endcase

        if (start_frame) begin
`ifdef USB_LOADER_SYNC_EN
            if (usb_data_in == SyncByte) begin
                state_d = StLoad;
                count_d = '0;
                train_d = mode_train;
            end
`else
            wr_en   = 1'b1;
            wr_addr = '0;
            count_d = 10'd1;
            train_d = mode_train;
            state_d = StLoad;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            count_q       <= '0;
            train_q       <= 1'b0;
            label_q       <= '0;
            label_valid_q <= 1'b0;
            label_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            train_q       <= train_d;
            label_q       <= label_d;
            label_valid_q <= label_valid_d;
            label_error_q <= label_error_d;
            overflow_q    <= overflow_d;
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_addr] <= usb_data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= ({1'b0, rd_addr} < NumPix) ? buffer[rd_addr] : 8'h00;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_ready = (state_q == StReady);
    assign label_out   = label_q;
    assign label_valid = label_valid_q;
    assign label_error = label_error_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q == StLoad) || (state_q == StLabel);

endmodule

// File: tb/tb_usb_image_loader.sv
// Bench for usb_image_loader: directed tables, hand sequences and a random run against a
// frame-level model (bytes counted per frame, not per FSM state).
module tb_usb_image_loader;

    localparam int NPIX = 784;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] usb_data_in;
    logic       usb_data_valid;
    logic       mode_train;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ready;
    logic       frame_ack;
    logic [7:0] label_out;
    logic       label_valid;
    logic       label_error;
    logic       overflow;
    logic       busy;

    int passed = 0;
    int total  = 0;

    usb_image_loader dut (
        .clk            (clk),
        .rst            (rst),
        .usb_data_in    (usb_data_in),
        .usb_data_valid (usb_data_valid),
        .mode_train     (mode_train),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .frame_ready    (frame_ready),
        .frame_ack      (frame_ack),
        .label_out      (label_out),
        .label_valid    (label_valid),
        .label_error    (label_error),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Frame-level model
    bit         m_held, m_in, m_train, m_lv, m_le, m_ovf;
    int         m_n;
    logic [7:0] m_mem [NPIX];
    logic [7:0] m_label, m_rd;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [7:0] lab;
        bit         err;
    } lab_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit mode, input bit ack,
                              input logic [9:0] ra);
        m_rd = (int'(ra) < NPIX) ? m_mem[int'(ra)] : 8'h00;
        if (m_held) begin
            if (ack) begin
                m_held = 0;
                m_lv   = 0;
                m_le   = 0;
            end else begin
                if (v) m_ovf = 1;
                return;
            end
        end
        if (!v) return;
        if (!m_in) begin
`ifdef USB_LOADER_SYNC_EN
            if (d == 8'hA5) begin
                m_in    = 1;
                m_n     = 0;
                m_train = mode;
            end
`else
            m_mem[0] = d;
            m_n      = 1;
            m_in     = 1;
            m_train  = mode;
`endif
        end else if (m_n < NPIX) begin
            m_mem[m_n] = d;
            m_n++;
            if (m_n == NPIX && !m_train) begin
                m_held = 1;
                m_in   = 0;
            end
        end else begin
            m_label = d;
            m_lv    = 1;
            m_le    = (d > 8'd9);
            m_held  = 1;
            m_in    = 0;
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {11'b0, rd_data, frame_ready, label_out, label_valid, label_error, overflow, busy};
    endfunction

    function automatic logic [31:0] model_vec();
        return {11'b0, m_rd, m_held, m_label, m_lv, m_le, m_ovf, m_in};
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input bit mode, input bit ack,
                        input logic [9:0] ra);
        usb_data_valid = v;
        usb_data_in    = d;
        mode_train     = mode;
        frame_ack      = ack;
        rd_addr        = ra;
        @(posedge clk);
        model_edge(v, d, mode, ack, ra);
        #1;
        check("cycle", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        usb_data_valid = 1'b0;
        frame_ack      = 1'b0;
        rst            = 1'b1;
        #1;
        m_held  = 0;
        m_in    = 0;
        m_n     = 0;
        m_lv    = 0;
        m_le    = 0;
        m_ovf   = 0;
        m_label = 8'h00;
        m_rd    = 8'h00;
        check("reset", dut_vec(), model_vec());
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Sends pixels [from, to) valued addr[7:0]^key; mode is only honoured on the first byte.
    task automatic load(input int from, input int to, input bit mode, input bit gaps,
                        input bit rd_same, input logic [7:0] key);
`ifdef USB_LOADER_SYNC_EN
        if (from == 0) step(1'b1, 8'hA5, mode, 1'b0, 10'd784);
`endif
        for (int i = from; i < to; i++) begin
            bit md;
            md = (i == from && from == 0) ? mode : 1'($urandom);
            if (gaps && ($urandom % 3 == 0)) step(1'b0, 8'($urandom), md, 1'b0, 10'd784);
            step(1'b1, 8'(i) ^ key, md, 1'b0, rd_same ? 10'(i) : 10'd784);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rd_vec_t  rt [7];
        lab_vec_t lt [6];
        rt = '{'{10'd300, 8'h2C}, '{10'd0, 8'h00}, '{10'd783, 8'h0F}, '{10'd255, 8'hFF},
               '{10'd256, 8'h00}, '{10'd784, 8'h00}, '{10'd1023, 8'h00}};
        lt = '{'{8'd7, 1'b0}, '{8'd12, 1'b1}, '{8'd9, 1'b0}, '{8'd10, 1'b1},
               '{8'd0, 1'b0}, '{8'd255, 1'b1}};
        usb_data_in = '0;
        mode_train  = 1'b0;
        rd_addr     = 10'd784;
        do_reset();
        check("reset_ready", 32'(frame_ready), 32'd0);
        check("reset_rd", 32'(rd_data), 32'd0);

        // Inference frame with gaps
        load(0, NPIX, 1'b0, 1'b1, 1'b0, 8'h00);
        check("inf_ready", 32'(frame_ready), 32'd1);
        check("inf_label_valid", 32'(label_valid), 32'd0);
        check("inf_busy", 32'(busy), 32'd0);

        // Dropped byte while held
        step(1'b1, 8'h55, 1'b0, 1'b0, 10'd784);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_ready", 32'(frame_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, rt[i].addr);
            check($sformatf("read_%0d", rt[i].addr), 32'(rd_data), 32'(rt[i].exp));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 10'd784);
        check("ack_ready", 32'(frame_ready), 32'd0);
        check("ack_ovf_sticky", 32'(overflow), 32'd1);

        // Training frames, read-during-write on the pixel being written
        for (int i = 0; i < 6; i++) begin
            load(0, NPIX, 1'b1, 1'(i % 2), 1'b1, 8'(i * 37 + 1));
            check("train_busy", 32'(busy), 32'd1);
            check("train_not_ready", 32'(frame_ready), 32'd0);
            step(1'b1, lt[i].lab, 1'b0, 1'b0, 10'd784);
            check($sformatf("label_out_%0d", i), 32'(label_out), 32'(lt[i].lab));
            check($sformatf("label_valid_%0d", i), 32'(label_valid), 32'd1);
            check($sformatf("label_error_%0d", i), 32'(label_error), 32'(lt[i].err));
            check($sformatf("label_ready_%0d", i), 32'(frame_ready), 32'd1);
            step(1'b0, 8'h00, 1'b0, 1'b1, 10'd784);
            check($sformatf("label_clr_%0d", i), 32'(label_valid), 32'd0);
        end

        // Back-to-back: ack and first byte together
        load(0, NPIX, 1'b0, 1'b0, 1'b0, 8'h5A);
        check("b2b_held", 32'(frame_ready), 32'd1);
`ifdef USB_LOADER_SYNC_EN
        step(1'b1, 8'hA5, 1'b0, 1'b1, 10'd784);
        step(1'b1, 8'h11, 1'b0, 1'b0, 10'd784);
`else
        step(1'b1, 8'h11, 1'b0, 1'b1, 10'd784);
`endif
        check("b2b_ready", 32'(frame_ready), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
        check("b2b_addr0", 32'(rd_data), 32'h11);

        // Reset at pixel 400, then a clean frame
        load(1, 400, 1'b0, 1'b1, 1'b0, 8'h00);
        check("mid_busy", 32'(busy), 32'd1);
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        load(0, NPIX - 1, 1'b0, 1'b1, 1'b0, 8'h3C);
        check("rst_pre_ready", 32'(frame_ready), 32'd0);
        load(NPIX - 1, NPIX, 1'b0, 1'b0, 1'b0, 8'h3C);
        check("rst_ready", 32'(frame_ready), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 10'd0);
        check("rst_frame_addr0", 32'(rd_data), 32'h3C);

`ifdef USB_LOADER_SYNC_EN
        step(1'b1, 8'h00, 1'b0, 1'b0, 10'd784);
        step(1'b1, 8'h33, 1'b0, 1'b0, 10'd784);
        check("sync_idle_busy", 32'(busy), 32'd0);
        check("sync_idle_ovf", 32'(overflow), 32'd0);
        load(0, NPIX, 1'b0, 1'b1, 1'b0, 8'h77);
        check("sync_ready", 32'(frame_ready), 32'd1);
        check("sync_ovf", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 10'd0);
        check("sync_addr0", 32'(rd_data), 32'h77);
`endif

        for (int c = 0; c < 15000; c++) begin
            if ($urandom % 4000 == 0) do_reset();
            else step(1'($urandom % 4 != 0), 8'($urandom), 1'($urandom),
                      1'($urandom % 40 == 0), 10'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
